// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and helpers for the FFT inter-stage delay line
package fft_pkg;

    localparam int DEF_WIDTH     = 9;
    localparam int DEF_LANES     = 16;
    localparam int DEF_MAX_DEPTH = 16;

    typedef logic signed [DEF_LANES-1:0][DEF_WIDTH-1:0] lane_vec_t;

    function automatic int ptr_width(input int max_depth);
        return (max_depth > 1) ? $clog2(max_depth) : 1;
    endfunction

    // A zero request still means one beat of delay; oversized requests pin to the ring size.
    function automatic int clamp_depth(input int sel, input int max_depth);
        if (sel < 1)
            return 1;
        if (sel > max_depth)
            return max_depth;
        return sel;
    endfunction

endpackage

// File: rtl/fft_ring_mem.sv
// rtl/fft_ring_mem.sv - beat ring storage, one write port and one registered read port
module fft_ring_mem
    import fft_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int DEPTH = DEF_MAX_DEPTH,
    parameter int AW    = ptr_width(DEF_MAX_DEPTH)
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               we,
    input  logic [AW-1:0]                      waddr,
    input  logic signed [LANES-1:0][WIDTH-1:0] wdata,
    input  logic                               re,
    input  logic [AW-1:0]                      raddr,
    output logic signed [LANES-1:0][WIDTH-1:0] rdata
);

    logic signed [LANES-1:0][WIDTH-1:0] mem [DEPTH];

    // Read samples the pre-write contents, so a same-address access returns the old beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            rdata <= '0;
        end else begin
            if (we)
                mem[waddr] <= wdata;
            if (re)
                rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_delay_line.sv
// rtl/fft_delay_line.sv - programmable beat delay for multi-lane FFT sample streams
module fft_delay_line
    import fft_pkg::*;
#(
    parameter int WIDTH     = 9,
    parameter int LANES     = 16,
    parameter int MAX_DEPTH = 16
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic                                      din_valid,
    input  logic signed [LANES-1:0][WIDTH-1:0]        din,
    input  logic [$clog2(MAX_DEPTH):0]                depth_sel,
    input  logic                                      flush,
    output logic signed [LANES-1:0][WIDTH-1:0]        dout,
    output logic                                      dout_valid
);

    localparam int PW = ptr_width(MAX_DEPTH);
    localparam int DW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [DW-1:0] fill;
    logic [DW-1:0] depth_q;
    logic [DW-1:0] d_eff;
    logic          depth_change;
    logic          flush_eff;
    logic          accept;
    logic          emit;

    assign d_eff        = DW'(clamp_depth(int'(depth_sel), MAX_DEPTH));
    // Retuning the depth with data in flight would misalign the stream, so it empties the line.
    assign depth_change = (depth_sel != depth_q) && (fill != '0);
    assign flush_eff    = flush || depth_change;
    assign accept       = din_valid && !flush_eff;
    assign emit         = accept && (fill >= d_eff);
    assign rd_ptr       = wr_ptr - d_eff[PW-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            fill       <= '0;
            depth_q    <= '0;
            dout_valid <= 1'b0;
        end else begin
            depth_q    <= depth_sel;
            dout_valid <= emit;
            if (flush_eff) begin
                wr_ptr <= '0;
                fill   <= '0;
            end else if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (fill != DW'(MAX_DEPTH))
                    fill <= fill + DW'(1);
            end
        end
    end

    // The ring's read register is the output register; it only loads on an emitted beat.
    fft_ring_mem #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .DEPTH (MAX_DEPTH),
        .AW    (PW)
    ) u_ring (
        .clk   (clk),
        .rstn  (rstn),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (emit),
        .raddr (rd_ptr),
        .rdata (dout)
    );

endmodule
